// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared UART state encoding, frame width, baud divisor |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } rx_state_e;

  // Clocks per bit; the transmitter uses the same computation.
  function automatic int baud_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// +------------------------------------------------------------------+
// | uart_rx_sync : two-flop synchronizer for the serial line,        |
// | resets to the idle (high) level. Rev 1.0                         |
// +------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// +------------------------------------------------------------------+
// | uart_receiver : 8N1 mid-bit sampling receiver with framing check;|
// | optional even parity via UART_RX_PARITY_EN. Rev 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000,
  parameter int BAUD_RATE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic       parity_error
);

  localparam int          BAUD_CNT  = baud_divisor(CLK_FREQ, BAUD_RATE);
  localparam int          HALF_CNT  = BAUD_CNT / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q, par_err_d;
  logic        parity_error_q, parity_error_d;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q + 16'd1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d      = par_err_q;
    parity_error_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      // A start bit that is no longer low at its midpoint is a glitch.
      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d         = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          par_err_d  = (^shift_q) ^ rx_s;
          state_d    = STOP;
        end
      end
`endif

      // Framing error outranks parity error; a bad frame never updates data_out.
      STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          if (!rx_s) begin
            frame_error_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            parity_error_d = 1'b1;
`endif
          end else begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end

      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      baud_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q      <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      par_err_q      <= par_err_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// +------------------------------------------------------------------+
// | tb_uart_receiver : directed self-checking bench for uart_receiver|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int BIT_CLKS = 100;
`ifdef UART_RX_PARITY_EN
  localparam int STROBE_OFS = 1053;
`else
  localparam int STROBE_OFS = 953;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic       parity_error;

  uart_receiver #(.CLK_FREQ(1000), .BAUD_RATE(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .busy         (busy),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int         dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0;
  int         dv_cyc = 0;
  logic       dv_busy = 1'b1;
  logic [7:0] dv_log[$];

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_busy <= busy;
      dv_log.push_back(data_out);
    end
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (data_valid && frame_error) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int fs       = 0;
  int dv0, fe0, pe0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    pe0 = pe_cnt;
  endtask

  // All drive tasks start and end 1 ns after a rising edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    fs = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`else
    if (!par_ok) fs = cyc - (9 * BIT_CLKS);
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset data_out", 32'(data_out), 32'h00);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset frame_error", 32'(frame_error), 32'h0);
    check("reset parity_error", 32'(parity_error), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(20);

    // Clean frame 0xA5
    snap();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    check("a5 dv count", 32'(dv_cnt - dv0), 32'd1);
    check("a5 data", 32'(dv_log[$]), 32'hA5);
    check("a5 fe count", 32'(fe_cnt - fe0), 32'd0);
    check("a5 busy at strobe", 32'(dv_busy), 32'h0);
    check("a5 strobe latency", 32'(dv_cyc - fs), 32'(STROBE_OFS));
    check("a5 data_out held", 32'(data_out), 32'hA5);

    // 20-clock glitch
    snap();
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch busy", 32'(busy), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    idle(100);
    check("glitch dv count", 32'(dv_cnt - dv0), 32'd0);
    check("glitch fe count", 32'(fe_cnt - fe0), 32'd0);
    check("glitch idle", 32'(busy), 32'h0);
    check("glitch data_out", 32'(data_out), 32'hA5);

    // 0x3C with stop bit low
    snap();
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(200);
    check("ferr fe count", 32'(fe_cnt - fe0), 32'd1);
    check("ferr dv count", 32'(dv_cnt - dv0), 32'd0);
    check("ferr data_out", 32'(data_out), 32'hA5);
    check("ferr busy", 32'(busy), 32'h0);

    // Back-to-back 0x00, 0xFF
    snap();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(20);
    check("b2b dv count", 32'(dv_cnt - dv0), 32'd2);
    check("b2b first", 32'(dv_log[dv_log.size() - 2]), 32'h00);
    check("b2b second", 32'(dv_log[$]), 32'hFF);
    check("b2b second latency", 32'(dv_cyc - fs), 32'(STROBE_OFS));
    check("b2b fe count", 32'(fe_cnt - fe0), 32'd0);

    // Reset during bit 4 of 0x81
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h81 >> i) & 8'h01));
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset state", 32'(dut.state_q), 32'd0);
    check("mid reset busy", 32'(busy), 32'h0);
    check("mid reset data_out", 32'(data_out), 32'h00);
    rst = 1'b0;
    idle(200);
    check("mid reset dv count", 32'(dv_cnt - dv0), 32'd0);
    check("mid reset fe count", 32'(fe_cnt - fe0), 32'd0);
    snap();
    send_frame(8'h42, 1'b1, 1'b1);
    idle(20);
    check("after reset dv count", 32'(dv_cnt - dv0), 32'd1);
    check("after reset data", 32'(data_out), 32'h42);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("bad parity pe count", 32'(pe_cnt - pe0), 32'd1);
    check("bad parity dv count", 32'(dv_cnt - dv0), 32'd0);
    check("bad parity data_out", 32'(data_out), 32'h42);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("good parity dv count", 32'(dv_cnt - dv0), 32'd1);
    check("good parity data", 32'(data_out), 32'h07);
    check("good parity pe count", 32'(pe_cnt - pe0), 32'd0);
`else
    check("parity_error never pulses", 32'(pe_cnt), 32'd0);
`endif
    check("dv and fe never together", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
